// File: rtl/cpu19_pkg.sv
// rtl/cpu19_pkg.sv - shared widths, opcodes, field positions and decoded bundle for the 19-bit CPU
package cpu19_pkg;

  localparam int XLEN = 19;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int IMMW = 8;
  localparam int OPW  = 5;

  localparam logic [OPW-1:0] OP_ADD  = 5'd0;
  localparam logic [OPW-1:0] OP_SUB  = 5'd1;
  localparam logic [OPW-1:0] OP_AND  = 5'd2;
  localparam logic [OPW-1:0] OP_OR   = 5'd3;
  localparam logic [OPW-1:0] OP_XOR  = 5'd4;
  localparam logic [OPW-1:0] OP_SLT  = 5'd5;
  localparam logic [OPW-1:0] OP_ADDI = 5'd8;
  localparam logic [OPW-1:0] OP_LDI  = 5'd9;
  localparam logic [OPW-1:0] OP_NOP  = 5'd15;
  localparam logic [OPW-1:0] OP_HALT = 5'd31;

  localparam int OP_HI  = 18;
  localparam int OP_LO  = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 11;
  localparam int RS1_HI = 10;
  localparam int RS1_LO = 8;
  localparam int RS2_HI = 7;
  localparam int RS2_LO = 5;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            we;
    logic            illegal;
  } ex_bundle_t;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMMW-1:0] imm);
    return {{(XLEN-IMMW){imm[IMMW-1]}}, imm};
  endfunction

endpackage

// File: rtl/scoreboard8.sv
// rtl/scoreboard8.sv - per-register pending bits and RAW/WAW stall detection
module scoreboard8
  import cpu19_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  input  logic            uses_rs1,
  input  logic [AW-1:0]   rs1,
  input  logic            uses_rs2,
  input  logic [AW-1:0]   rs2,
  input  logic            writes_rd,
  input  logic [AW-1:0]   rd,
  output logic            stall,
  output logic [NREG-1:0] pending
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic            hit_rs1;
  logic            hit_rs2;
  logic            hit_rd;

  // A register being written back this cycle is no longer a hazard, so
  // the same-cycle clear masks the pending bit before the hazard check.
  always_comb begin
    hit_rs1 = pending_q[rs1] && !(clr_en && (clr_addr == rs1));
    hit_rs2 = pending_q[rs2] && !(clr_en && (clr_addr == rs2));
    hit_rd  = pending_q[rd]  && !(clr_en && (clr_addr == rd));
    stall   = (uses_rs1 && hit_rs1) || (uses_rs2 && hit_rs2) || (writes_rd && hit_rd);
  end

  // Next pending state: clear applied first so a new issue to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en) pending_d[set_addr] = 1'b1;
  end

  // Pending register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - decode, operand read with writeback forwarding, hazard stall and issue register
module decode_issue_stage
  import cpu19_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  output logic            if_ready,
  output logic [AW-1:0]   rf_a1,
  output logic [AW-1:0]   rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [OPW-1:0]  ex_op,
  output logic [AW-1:0]   ex_rd,
  output logic [XLEN-1:0] ex_opa,
  output logic [XLEN-1:0] ex_opb,
  output logic            ex_we,
  output logic            ex_illegal
);

  logic [OPW-1:0]  op;
  logic [AW-1:0]   rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [IMMW-1:0] imm8;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            writes_rd;
  logic            illegal;
  logic            has_imm;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            stall;
  logic            accept;
  logic [NREG-1:0] pending;

  ex_bundle_t ex_q;
  ex_bundle_t ex_d;
  logic       ex_valid_q;
  logic       ex_valid_d;

  assign op    = if_instr[OP_HI:OP_LO];
  assign rd    = if_instr[RD_HI:RD_LO];
  assign rs1   = if_instr[RS1_HI:RS1_LO];
  assign rs2   = if_instr[RS2_HI:RS2_LO];
  assign imm8  = if_instr[IMM_HI:IMM_LO];
  assign rf_a1 = rs1;
  assign rf_a2 = rs2;

  // Opcode class decode: which fields are sources, whether rd is written.
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    has_imm   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_ADDI: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        has_imm   = 1'b1;
      end
      OP_LDI: begin
        writes_rd = 1'b1;
        has_imm   = 1'b1;
      end
      OP_NOP, OP_HALT: begin
      end
      default: illegal = 1'b1;
    endcase
  end

  // Operand selection; the register file only sees the write at the next
  // edge, so a same-cycle writeback is bypassed here.
  always_comb begin
    fwd1 = (wb_we && (wb_addr == rs1)) ? wb_data : rf_rd1;
    fwd2 = (wb_we && (wb_addr == rs2)) ? wb_data : rf_rd2;
    opa  = uses_rs1 ? fwd1 : '0;
    if (uses_rs2)     opb = fwd2;
    else if (has_imm) opb = sext_imm(imm8);
    else              opb = '0;
  end

  scoreboard8 u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (accept && writes_rd),
    .set_addr  (rd),
    .clr_en    (wb_we),
    .clr_addr  (wb_addr),
    .uses_rs1  (uses_rs1),
    .rs1       (rs1),
    .uses_rs2  (uses_rs2),
    .rs2       (rs2),
    .writes_rd (writes_rd),
    .rd        (rd),
    .stall     (stall),
    .pending   (pending)
  );

  assign if_ready = rst && !stall && (!ex_valid_q || ex_ready);
  assign accept   = if_valid && if_ready;

  // Issue register: load on accept, drain on consume, otherwise hold.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (accept) begin
      ex_d.op      = op;
      ex_d.rd      = rd;
      ex_d.opa     = opa;
      ex_d.opb     = opb;
      ex_d.we      = writes_rd;
      ex_d.illegal = illegal;
      ex_valid_d   = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // Issue register flops; reset drops any in-flight bundle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_op      = ex_q.op;
  assign ex_rd      = ex_q.rd;
  assign ex_opa     = ex_q.opa;
  assign ex_opb     = ex_q.opb;
  assign ex_we      = ex_q.we;
  assign ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb/tb_decode_issue_stage.sv - scoreboard bench for decode_issue_stage
module tb_decode_issue_stage;
  import cpu19_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [18:0] if_instr;
  logic        if_ready;
  logic [2:0]  rf_a1;
  logic [2:0]  rf_a2;
  logic [18:0] rf_rd1;
  logic [18:0] rf_rd2;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [18:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_op;
  logic [2:0]  ex_rd;
  logic [18:0] ex_opa;
  logic [18:0] ex_opb;
  logic        ex_we;
  logic        ex_illegal;

  int checks   = 0;
  int failures = 0;

  logic [18:0] regs [8];
  ex_bundle_t  exp_q [$];

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_we(ex_we), .ex_illegal(ex_illegal)
  );

  assign rf_rd1 = regs[rf_a1];
  assign rf_rd2 = regs[rf_a2];

  always @(posedge clk) begin
    if (wb_we) regs[wb_addr] <= wb_data;
  end

  function automatic logic [18:0] enc_r(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 5'b0};
  endfunction

  function automatic logic [18:0] enc_i(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [7:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic ex_bundle_t mk(input logic [4:0] op, input logic [2:0] rd,
                                    input logic [18:0] opa, input logic [18:0] opb,
                                    input logic we, input logic ill);
    ex_bundle_t b;
    b.op = op; b.rd = rd; b.opa = opa; b.opb = opb; b.we = we; b.illegal = ill;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [18:0] instr, input ex_bundle_t exp, output int waited);
    if_valid = 1'b1;
    if_instr = instr;
    waited   = 0;
    #1;
    while (!if_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!if_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: instr %h never accepted", instr);
    end else begin
      exp_q.push_back(exp);
      tick();
    end
    if_valid = 1'b0;
  endtask

  // Monitor: every consumed bundle is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst && ex_valid && ex_ready) begin
      ex_bundle_t a;
      ex_bundle_t e;
      a = mk(ex_op, ex_rd, ex_opa, ex_opb, ex_we, ex_illegal);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL bundle_unexpected: got %h expected none", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL bundle: got %h expected %h", a, e);
        end
      end
    end
  end

  initial begin
    int w;
    rst = 1'b0; if_valid = 1'b0; if_instr = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    ex_ready = 1'b1;
    tick();
    tick();
    chk("reset_ex_valid", ex_valid, 0);
    chk("reset_if_ready", if_ready, 0);
    chk("reset_pending", dut.u_sb.pending_q, 0);
    chk("reset_ex_opa", ex_opa, 0);

    // Preload R2=5, R3=3
    rst = 1'b1;
    wb_we = 1'b1; wb_addr = 3'd2; wb_data = 19'd5;
    tick();
    wb_addr = 3'd3; wb_data = 19'd3;
    tick();
    wb_we = 1'b0;

    // Basic issue
    issue(enc_r(OP_ADD, 3'd1, 3'd2, 3'd3), mk(5'd0, 3'd1, 19'd5, 19'd3, 1'b1, 1'b0), w);
    chk("t1_wait", w, 0);
    chk("t1_ex_valid", ex_valid, 1);
    chk("t1_pending", dut.u_sb.pending_q, 8'h02);

    // RAW stall, released by same-cycle writeback with forwarding
    if_valid = 1'b1;
    if_instr = enc_i(OP_ADDI, 3'd4, 3'd1, 8'hFF);
    #1;
    chk("t2_stall0", if_ready, 0);
    tick();
    chk("t2_stall1", if_ready, 0);
    wb_we = 1'b1; wb_addr = 3'd1; wb_data = 19'd8;
    #1;
    chk("t2_release", if_ready, 1);
    exp_q.push_back(mk(OP_ADDI, 3'd4, 19'd8, 19'h7FFFF, 1'b1, 1'b0));
    tick();
    wb_we = 1'b0; if_valid = 1'b0;
    chk("t2_pending", dut.u_sb.pending_q, 8'h10);

    // Backpressure for three cycles
    ex_ready = 1'b0;
    if_valid = 1'b1;
    if_instr = enc_i(OP_LDI, 3'd6, 3'd0, 8'h05);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", ex_valid, 1);
      chk("t3_hold_op", ex_op, OP_ADDI);
      chk("t3_hold_opa", ex_opa, 19'd8);
      chk("t3_hold_opb", ex_opb, 19'h7FFFF);
      chk("t3_if_ready", if_ready, 0);
      tick();
    end
    ex_ready = 1'b1;
    #1;
    chk("t3_resume", if_ready, 1);
    exp_q.push_back(mk(OP_LDI, 3'd6, 19'd0, 19'd5, 1'b1, 1'b0));
    tick();
    if_valid = 1'b0;
    chk("t3_pending", dut.u_sb.pending_q, 8'h50);

    // WAW stall and set/clear collision on R5
    issue(enc_i(OP_LDI, 3'd5, 3'd0, 8'h01), mk(OP_LDI, 3'd5, 19'd0, 19'd1, 1'b1, 1'b0), w);
    chk("t4_pending_a", dut.u_sb.pending_q, 8'h70);
    if_valid = 1'b1;
    if_instr = enc_i(OP_LDI, 3'd5, 3'd0, 8'd20);
    #1;
    chk("t4_waw_stall", if_ready, 0);
    wb_we = 1'b1; wb_addr = 3'd5; wb_data = 19'h11;
    #1;
    chk("t4_collide_ready", if_ready, 1);
    exp_q.push_back(mk(OP_LDI, 3'd5, 19'd0, 19'd20, 1'b1, 1'b0));
    tick();
    wb_we = 1'b0; if_valid = 1'b0;
    chk("t4_pending_b", dut.u_sb.pending_q, 8'h70);

    // Illegal opcode never stalls and leaves pending alone
    issue(enc_i(OP_LDI, 3'd2, 3'd0, 8'h07), mk(OP_LDI, 3'd2, 19'd0, 19'd7, 1'b1, 1'b0), w);
    chk("t5_pending_a", dut.u_sb.pending_q, 8'h74);
    issue(enc_r(5'd20, 3'd2, 3'd2, 3'd2), mk(5'd20, 3'd2, 19'd0, 19'd0, 1'b0, 1'b1), w);
    chk("t5_wait", w, 0);
    chk("t5_pending_b", dut.u_sb.pending_q, 8'h74);
    tick();

    // Reset mid-operation
    rst = 1'b0;
    tick();
    rst = 1'b1;
    issue(enc_i(OP_LDI, 3'd1, 3'd0, 8'h01), mk(OP_LDI, 3'd1, 19'd0, 19'd1, 1'b1, 1'b0), w);
    issue(enc_i(OP_LDI, 3'd3, 3'd0, 8'h02), mk(OP_LDI, 3'd3, 19'd0, 19'd2, 1'b1, 1'b0), w);
    chk("t6_back_to_back", w, 0);
    ex_ready = 1'b0;
    chk("t6_pre_valid", ex_valid, 1);
    chk("t6_pre_pending", dut.u_sb.pending_q, 8'h0A);
    rst = 1'b0;
    wb_we = 1'b1; wb_addr = 3'd1; wb_data = 19'h22;
    #1;
    chk("t6_ready_in_reset", if_ready, 0);
    tick();
    void'(exp_q.pop_back());
    chk("t6_valid", ex_valid, 0);
    chk("t6_pending", dut.u_sb.pending_q, 0);
    chk("t6_ex_rd", ex_rd, 0);
    chk("t6_ex_opb", ex_opb, 0);
    chk("t6_ready_still", if_ready, 0);
    rst = 1'b1;
    ex_ready = 1'b1;
    wb_addr = 3'd3; wb_data = 19'd3;
    tick();
    wb_we = 1'b0;
    chk("t6_pending_after_wb", dut.u_sb.pending_q, 0);
    issue(enc_r(OP_ADD, 3'd7, 3'd2, 3'd3), mk(OP_ADD, 3'd7, 19'd5, 19'd3, 1'b1, 1'b0), w);
    chk("t6_post_wait", w, 0);
    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
